// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

  localparam int FETCH_XLEN   = 32;
  localparam int MIPS_PC_STEP = 4;

  // Default queue entry: a fetched word and the address it came from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

  // Width needed to hold an occupancy value in 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, parametrised on depth and entry type
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  entry_t                        din,
  output entry_t                        dout,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            pop_eff;
  logic            push_eff;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty queue is ignored; a push is accepted when there is room
  // or the head is leaving in the same cycle.
  always_comb begin
    pop_eff  = pop && (count != '0);
    push_eff = push && ((count != CW'(DEPTH)) || pop_eff);
  end

  // Pointer and occupancy tracking; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= next_ptr(wr_ptr);
      if (pop_eff)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_eff && !flush && !reset) mem[wr_ptr] <= din;
  end

  // Present zeros when empty so the head fields have defined values after reset.
  always_comb begin
    dout = (count == '0) ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching instruction-fetch front end with redirect flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = MIPS_PC_STEP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_en,
  output logic [XLEN-1:0]               imem_addr,
  input  logic [XLEN-1:0]               imem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_instr,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_pc4,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;
  logic            room;
  entry_t          push_entry;
  entry_t          head;

  // Issue only when the queue can absorb every word already owed to it,
  // counting the head that leaves this cycle as freed space.
  always_comb begin
    pop        = out_valid && out_ready;
    occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    room       = occupancy < (CW + 1)'(DEPTH);
    imem_en    = !reset && !redirect_valid && room;
    imem_addr  = pc_q;
    push       = inflight_q && !redirect_valid;
    push_entry = '{instr: imem_rdata, pc: inflight_pc_q};
    out_valid  = (count != '0);
    out_instr  = head.instr;
    out_pc     = head.pc;
    out_pc4    = head.pc + XLEN'(PC_STEP);
  end

  // Fetch PC and in-flight tracking; a redirect drops the outstanding read
  // and word-aligns the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ~XLEN'(3);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_en;
      if (imem_en) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + XLEN'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready_a;

  logic        en_a, valid_a;
  logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc4_a;
  logic [2:0]  count_a;

  logic        en_b, valid_b;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc4_b;
  logic [2:0]  count_b;

  int total  = 0;
  int passed = 0;
  int issues = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (en_a),
    .imem_addr      (addr_a),
    .imem_rdata     (rdata_a),
    .out_valid      (valid_a),
    .out_ready      (ready_a),
    .out_instr      (instr_a),
    .out_pc         (pc_a),
    .out_pc4        (pc4_a),
    .count          (count_a)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_en        (en_b),
    .imem_addr      (addr_b),
    .imem_rdata     (rdata_b),
    .out_valid      (valid_b),
    .out_ready      (1'b1),
    .out_instr      (instr_b),
    .out_pc         (pc_b),
    .out_pc4        (pc4_b),
    .count          (count_b)
  );

  // Instruction memories: one-cycle read latency, word = address ^ SALT.
  always @(posedge clk) begin
    if (en_a) rdata_a <= addr_a ^ SALT;
    if (en_b) rdata_b <= addr_b ^ SALT;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ready_a = 1'b0;
    rdata_a = '0; rdata_b = '0;
    repeat (3) @(negedge clk);
    #1;

    // Reset values
    chk("rst_en",    32'(en_a),    32'd0);
    chk("rst_addr",  addr_a,       32'h0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_instr", instr_a,      32'h0);
    chk("rst_pc",    pc_a,         32'h0);
    chk("rst_pc4",   pc4_a,        32'h4);
    chk("rst_addr_b", addr_b,      32'hFFFF_FFF8);

    // Cold start, streaming with ready held high; dut_b covers the PC wrap
    @(negedge clk);
    reset = 1'b0; ready_a = 1'b1;
    #1;
    chk("c0_en",   32'(en_a), 32'd1);
    chk("c0_addr", addr_a,    32'h0);
    step();
    chk("c1_valid", 32'(valid_a), 32'd0);
    chk("c1_addr",  addr_a,       32'h4);
    for (int n = 2; n < 8; n++) begin
      step();
      chk("stream_valid", 32'(valid_a), 32'd1);
      chk("stream_pc",    pc_a,    32'(4 * (n - 2)));
      chk("stream_instr", instr_a, 32'(4 * (n - 2)) ^ SALT);
      chk("stream_pc4",   pc4_a,   32'(4 * (n - 1)));
      if (n < 6) begin
        chk("wrap_valid", 32'(valid_b), 32'd1);
        chk("wrap_pc",    pc_b, 32'hFFFF_FFF8 + 32'(4 * (n - 2)));
      end
    end

    // Decode stall: exactly DEPTH issues, then fetch holds
    @(negedge clk);
    reset = 1'b1; ready_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      issues += int'(en_a);
      step();
    end
    chk("stall_issues", 32'(issues),  32'd4);
    chk("stall_count",  32'(count_a), 32'd4);
    chk("stall_en",     32'(en_a),    32'd0);
    chk("stall_addr",   addr_a,       32'h10);
    chk("stall_head",   pc_a,         32'h0);

    // Release ready: drain 0,4,8,12 and continue at 16 without a gap
    ready_a = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      chk("drain_valid", 32'(valid_a), 32'd1);
      chk("drain_pc",    pc_a,    32'(4 * j));
      chk("drain_instr", instr_a, 32'(4 * j) ^ SALT);
      step();
    end
    chk("pre_redir_count", 32'(count_a), 32'd3);
    chk("pre_redir_head",  pc_a,         32'h18);

    // Redirect with 3 queued and one in flight; target is forced to word alignment
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_no_issue", 32'(en_a), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0; ready_a = 1'b0;
    #1;
    chk("r1_count", 32'(count_a), 32'd0);
    chk("r1_valid", 32'(valid_a), 32'd0);
    chk("r1_addr",  addr_a,       32'h100);
    chk("r1_en",    32'(en_a),    32'd1);
    step();
    chk("r2_count", 32'(count_a), 32'd0);
    step();
    chk("r3_valid", 32'(valid_a), 32'd1);
    chk("r3_pc",    pc_a,         32'h100);
    chk("r3_instr", instr_a,      32'hA5A5_0100);
    chk("r3_count", 32'(count_a), 32'd1);

    // Steer the head to 0x20, then redirect while popping it
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    step();
    chk("q3_pc",    pc_a,         32'h20);
    chk("q3_count", 32'(count_a), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200; ready_a = 1'b1;
    #1;
    chk("pop_redir_valid", 32'(valid_a), 32'd1);
    chk("pop_redir_pc",    pc_a,         32'h20);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("p1_count", 32'(count_a), 32'd0);
    chk("p1_addr",  addr_a,       32'h200);
    step();
    chk("p2_valid", 32'(valid_a), 32'd0);
    step();
    chk("p3_valid", 32'(valid_a), 32'd1);
    chk("p3_pc",    pc_a,         32'h200);
    chk("p3_pc4",   pc4_a,        32'h204);
    chk("p3_instr", instr_a,      32'hA5A5_0200);

    // Build up count=3 with a read in flight, then reset mid-operation
    ready_a = 1'b0;
    step();
    step();
    chk("pre_rst_count", 32'(count_a), 32'd3);
    chk("pre_rst_head",  pc_a,         32'h200);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_count", 32'(count_a), 32'd0);
    chk("mid_rst_addr",  addr_a,       32'h0);
    chk("mid_rst_pc4",   pc4_a,        32'h4);
    reset = 1'b0;
    step();
    chk("post_rst_count", 32'(count_a), 32'd0);
    chk("post_rst_valid", 32'(valid_a), 32'd0);
    chk("post_rst_addr",  addr_a,       32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
